// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Write-back arbiter and clear sequencer for the 32x32 register file.
// The ALU and load requesters share the single register-file write port.
// A 32-cycle clear sequence zeroes every register through the same port.
//
// Handshake: a transfer happens in a cycle where valid and ready are both
// high. Ready is combinational and is never high without its valid. A
// requester that is not granted must hold valid/addr/data stable until it is
// granted. At most one transfer is accepted per cycle.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   alu_valid/addr/data ALU write request
//   alu_ready           ALU write accepted this cycle
//   ld_valid/addr/data  load write request
//   ld_ready            load write accepted this cycle
//   clr_start           one-cycle pulse that starts the clear sequence
//   busy                high while the clear sequence runs
//   clr_done            one-cycle pulse, aligned with the address-31 write
//   reg_w/w_reg_addr/w_data  registered register-file write port
//   dbg_state           current FSM state (0 = IDLE, 1 = CLEAR)
//
// Parameter:
//   NREG   number of registers cleared; must be 32 (address width is 5)
//
// Build option:
//   REGWB_R0_PROTECT_EN  when defined, requester writes to address 0 are
//                        accepted but never issued to the register file.
//                        Clear-sequence writes to address 0 still happen.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int NREG = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   input  logic [4:0]  alu_addr,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        ld_valid,
   input  logic [4:0]  ld_addr,
   input  logic [31:0] ld_data,
   output logic        ld_ready,
   input  logic        clr_start,
   output logic        busy,
   output logic        clr_done,
   output logic        reg_w,
   output logic [4:0]  w_reg_addr,
   output logic [31:0] w_data,
   output logic        dbg_state
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   // last_grant encoding
   localparam logic GRANT_ALU = 1'b0;
   localparam logic GRANT_LD  = 1'b1;

   localparam logic [4:0] LAST_ADDR = 5'(NREG - 1);

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        last_grant_q, last_grant_d;
   logic        reg_w_q, reg_w_d;
   logic [4:0]  addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        clr_done_q, clr_done_d;

   logic        grant_alu, grant_ld;

   // Decides whether an accepted requester write actually reaches the
   // register file.
   function automatic logic req_write_en(input logic [4:0] addr);
`ifdef REGWB_R0_PROTECT_EN
      return (addr != 5'd0);
`else
      return 1'b1;
`endif
   endfunction

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= 5'd0;
         last_grant_q <= GRANT_LD;   // ALU wins the first tie
         reg_w_q      <= 1'b0;
         addr_q       <= 5'd0;
         data_q       <= 32'd0;
         clr_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         reg_w_q      <= reg_w_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         clr_done_q   <= clr_done_d;
      end
   end

   // Next-state, grant and write-port logic
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      reg_w_d      = 1'b0;
      addr_d       = addr_q;     // address/data hold when nothing is written
      data_d       = data_q;
      clr_done_d   = 1'b0;
      grant_alu    = 1'b0;
      grant_ld     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (clr_start) begin
               // Clear request pre-empts both requesters this cycle.
               state_d = S_CLEAR;
               cnt_d   = 5'd0;
            end else begin
               // Round robin: on a tie the requester not granted last wins.
               grant_alu = alu_valid && (!ld_valid || (last_grant_q == GRANT_LD));
               grant_ld  = ld_valid && !grant_alu;

               if (grant_alu) begin
                  reg_w_d      = req_write_en(alu_addr);
                  addr_d       = alu_addr;
                  data_d       = alu_data;
                  last_grant_d = GRANT_ALU;
               end else if (grant_ld) begin
                  reg_w_d      = req_write_en(ld_addr);
                  addr_d       = ld_addr;
                  data_d       = ld_data;
                  last_grant_d = GRANT_LD;
               end
            end
         end

         S_CLEAR: begin
            // clr_start is ignored here; requesters stay blocked.
            reg_w_d = 1'b1;
            addr_d  = cnt_q;
            data_d  = 32'd0;
            if (cnt_q == LAST_ADDR) begin
               // cnt parks at the last address rather than wrapping.
               state_d    = S_IDLE;
               clr_done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign alu_ready  = grant_alu;
   assign ld_ready   = grant_ld;
   assign busy       = (state_q == S_CLEAR);
   assign clr_done   = clr_done_q;
   assign reg_w      = reg_w_q;
   assign w_reg_addr = addr_q;
   assign w_data     = data_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed bench for regfile_wb_arbiter. Inputs change 1 ns after a rising
// edge; combinational readies are sampled 1 ns later, registered outputs are
// sampled 1 ns after the following rising edge.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_addr;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        ld_valid;
   logic [4:0]  ld_addr;
   logic [31:0] ld_data;
   logic        ld_ready;
   logic        clr_start;
   logic        busy;
   logic        clr_done;
   logic        reg_w;
   logic [4:0]  w_reg_addr;
   logic [31:0] w_data;
   logic        dbg_state;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.NREG(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .alu_valid  (alu_valid),
      .alu_addr   (alu_addr),
      .alu_data   (alu_data),
      .alu_ready  (alu_ready),
      .ld_valid   (ld_valid),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .ld_ready   (ld_ready),
      .clr_start  (clr_start),
      .busy       (busy),
      .clr_done   (clr_done),
      .reg_w      (reg_w),
      .w_reg_addr (w_reg_addr),
      .w_data     (w_data),
      .dbg_state  (dbg_state)
   );

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
      alu_valid = v;
      alu_addr  = a;
      alu_data  = d;
   endtask

   task automatic set_ld(input logic v, input logic [4:0] a, input logic [31:0] d);
      ld_valid = v;
      ld_addr  = a;
      ld_data  = d;
   endtask

   task automatic idle_inputs();
      set_alu(1'b0, 5'd0, 32'd0);
      set_ld(1'b0, 5'd0, 32'd0);
      clr_start = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_reg_w"},     reg_w,      32'd0);
      check({tag, "_addr"},      w_reg_addr, 32'd0);
      check({tag, "_data"},      w_data,     32'd0);
      check({tag, "_alu_ready"}, alu_ready,  32'd0);
      check({tag, "_ld_ready"},  ld_ready,   32'd0);
      check({tag, "_busy"},      busy,       32'd0);
      check({tag, "_clr_done"},  clr_done,   32'd0);
      check({tag, "_state"},     dbg_state,  32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("rst");
      rst = 1'b0;

      // ALU-only write
      set_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
      #1;
      check("alu_only_ready",    alu_ready, 32'd1);
      check("alu_only_ld_ready", ld_ready,  32'd0);
      tick();
      set_alu(1'b0, 5'd0, 32'd0);
      check("alu_only_reg_w", reg_w,      32'd1);
      check("alu_only_addr",  w_reg_addr, 32'd5);
      check("alu_only_data",  w_data,     32'hDEAD_BEEF);
      tick();
      check("idle_reg_w",     reg_w,      32'd0);
      check("idle_addr_hold", w_reg_addr, 32'd5);
      check("idle_data_hold", w_data,     32'hDEAD_BEEF);

      // Load-only write (leaves last_grant = load)
      set_ld(1'b1, 5'd9, 32'h1234_5678);
      #1;
      check("ld_only_ready",     ld_ready,  32'd1);
      check("ld_only_alu_ready", alu_ready, 32'd0);
      tick();
      set_ld(1'b0, 5'd0, 32'd0);
      check("ld_only_reg_w", reg_w,      32'd1);
      check("ld_only_addr",  w_reg_addr, 32'd9);
      check("ld_only_data",  w_data,     32'h1234_5678);

      // Contention: grants alternate ALU, load, ALU, load with no bubbles
      set_alu(1'b1, 5'd1, 32'hA1A1_A1A1);
      set_ld(1'b1, 5'd2, 32'hB2B2_B2B2);
      for (int i = 0; i < 4; i++) begin
         logic exp_alu;
         exp_alu = ((i % 2) == 0);
         #1;
         check($sformatf("cont%0d_alu_ready", i), alu_ready, {31'd0, exp_alu});
         check($sformatf("cont%0d_ld_ready", i),  ld_ready,  {31'd0, !exp_alu});
         tick();
         check($sformatf("cont%0d_reg_w", i), reg_w, 32'd1);
         check($sformatf("cont%0d_addr", i),  w_reg_addr, exp_alu ? 32'd1 : 32'd2);
         check($sformatf("cont%0d_data", i),  w_data, exp_alu ? 32'hA1A1_A1A1 : 32'hB2B2_B2B2);
      end

      // Clear with both requesters valid; extra clr_start mid-sequence is ignored
      clr_start = 1'b1;
      #1;
      check("clr_start_alu_ready", alu_ready, 32'd0);
      check("clr_start_ld_ready",  ld_ready,  32'd0);
      tick();
      clr_start = 1'b0;
      for (int k = 0; k < 32; k++) begin
         if (k == 5) clr_start = 1'b1;
         #1;
         check($sformatf("clr%0d_alu_ready", k), alu_ready, 32'd0);
         check($sformatf("clr%0d_ld_ready", k),  ld_ready,  32'd0);
         check($sformatf("clr%0d_busy", k),      busy,      32'd1);
         tick();
         clr_start = 1'b0;
         check($sformatf("clr%0d_reg_w", k),    reg_w,      32'd1);
         check($sformatf("clr%0d_addr", k),     w_reg_addr, 32'(k));
         check($sformatf("clr%0d_data", k),     w_data,     32'd0);
         check($sformatf("clr%0d_done", k),     clr_done,   (k == 31) ? 32'd1 : 32'd0);
         check($sformatf("clr%0d_busy_after", k), busy,     (k == 31) ? 32'd0 : 32'd1);
      end
      // Requesters grantable right after busy falls; ALU wins (last grant was load)
      #1;
      check("post_clr_alu_ready", alu_ready, 32'd1);
      check("post_clr_ld_ready",  ld_ready,  32'd0);
      tick();
      idle_inputs();
      check("post_clr_reg_w", reg_w,      32'd1);
      check("post_clr_addr",  w_reg_addr, 32'd1);
      check("post_clr_data",  w_data,     32'hA1A1_A1A1);
      check("post_clr_done",  clr_done,   32'd0);

      // Reset in the middle of a clear at cnt = 10
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      repeat (10) tick();
      check("mid_clr_addr", w_reg_addr, 32'd9);
      check("mid_clr_busy", busy,       32'd1);
      rst = 1'b1;
      #1;
      check_reset_values("mid_rst");
      tick();
      rst = 1'b0;
      for (int j = 0; j < 3; j++) begin
         tick();
         check($sformatf("after_rst%0d_done", j),  clr_done, 32'd0);
         check($sformatf("after_rst%0d_reg_w", j), reg_w,    32'd0);
         check($sformatf("after_rst%0d_busy", j),  busy,     32'd0);
      end
      // last_grant is back to load, so ALU wins the tie
      set_alu(1'b1, 5'd3, 32'h0000_0033);
      set_ld(1'b1, 5'd4, 32'h0000_0044);
      #1;
      check("rst_tie_alu_ready", alu_ready, 32'd1);
      check("rst_tie_ld_ready",  ld_ready,  32'd0);
      tick();
      idle_inputs();
      check("rst_tie_addr", w_reg_addr, 32'd3);
      check("rst_tie_data", w_data,     32'h0000_0033);

      // Write to register 0
      set_alu(1'b1, 5'd0, 32'd7);
      #1;
      check("r0_alu_ready", alu_ready, 32'd1);
      tick();
      idle_inputs();
`ifdef REGWB_R0_PROTECT_EN
      check("r0_reg_w", reg_w, 32'd0);
`else
      check("r0_reg_w", reg_w,      32'd1);
      check("r0_addr",  w_reg_addr, 32'd0);
      check("r0_data",  w_data,     32'd7);
`endif
      tick();
      check("final_reg_w", reg_w, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and sequencer for the 32x32 register file. Two requesters (ALU result, load result) share the register file's single write port through valid/ready handshakes with round-robin arbitration. The block also runs a 32-cycle clear sequence that zeroes every register through the same port. It sits between the execute/memory stages and the register file's reg_w / w_reg_addr / w_data inputs.

## Interface
Parameters:
- NREG, 32, number of registers to clear; must be 32 (address width fixed at 5).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous reset, active-high.
- alu_valid  in  1  ALU requester has a write pending.
- alu_addr  in  5  ALU destination register.
- alu_data  in  32  ALU write data.
- alu_ready  out  1  ALU write accepted this cycle.
- ld_valid  in  1  load requester has a write pending.
- ld_addr  in  5  load destination register.
- ld_data  in  32  load write data.
- ld_ready  out  1  load write accepted this cycle.
- clr_start  in  1  one-cycle pulse; starts the clear sequence.
- busy  out  1  high while the clear sequence runs.
- clr_done  out  1  one-cycle pulse after the last clear write.
- reg_w  out  1  register-file write enable.
- w_reg_addr  out  5  register-file write address.
- w_data  out  32  register-file write data.

Decided: one clock; reset is asynchronous and active-high.

## Operation
- States: IDLE, CLEAR. Reset puts the block in IDLE.
- IDLE:
  - A transfer occurs when valid and ready are both high.
  - The ready signals are combinational from state, both valid signals, clr_start and the last_grant flop. Ready is never high without the matching valid.
  - If only one requester is valid, that requester gets ready.
  - If both are valid, the requester not granted last gets ready. last_grant updates on every transfer. last_grant resets to "load", so the ALU wins the first tie.
  - At most one transfer per cycle.
  - The losing requester must hold its valid, addr and data stable until it is granted.
- Output register: on a transfer, reg_w, w_reg_addr and w_data are loaded the next edge with the granted addr/data. With no transfer, reg_w = 0, and addr/data hold their previous values.
- clr_start in IDLE:
  - Takes priority over both requesters: both ready signals are 0 in that cycle.
  - Next state is CLEAR, with cnt = 0.
- CLEAR:
  - Both ready signals are 0 and busy = 1.
  - Each cycle the output register is loaded with reg_w = 1, w_reg_addr = cnt, w_data = 0, and cnt increments.
  - After the cnt = 31 write is issued, state returns to IDLE. clr_done pulses for one cycle, coincident with the registered write to address 31.
  - clr_start is ignored while in CLEAR.
  - cnt is 5 bits. It reaches 31 and does not wrap back into CLEAR.
- Reset mid-CLEAR aborts the sequence immediately. Partially cleared registers are not restored.

## Timing
- Reset values: reg_w 0, w_reg_addr 0, w_data 0, alu_ready 0, ld_ready 0, busy 0, clr_done 0, cnt 0, state IDLE, last_grant = load.
- Write latency: a transfer at edge N produces reg_w = 1 during the cycle after edge N, so the register file commits it at edge N+1.
- Throughput: one write per cycle. Back-to-back transfers from alternating requesters are sustained with no bubbles.
- Clear: clr_start sampled at edge N.
  - busy is high from after edge N until after edge N+32.
  - Clear writes are presented during cycles N+1..N+32.
  - clr_done is high in the cycle of the address-31 write.
  - Requesters are next grantable in the cycle after busy falls.
- A transfer accepted in the cycle before clr_start still commits. Its write precedes the address-0 clear write, so it is overwritten if its address is cleared.

## Configuration
- REGWB_R0_PROTECT_EN:
  - Defined: a requester transfer with addr = 0 is accepted (ready pulses normally), but reg_w stays 0 for it, so register 0 is never written by requesters. Clear-sequence writes to address 0 are still issued.
  - Undefined: address 0 is written like any other address.

## Test plan
- ALU only: alu_valid = 1, addr 5, data 0xDEADBEEF -> alu_ready = 1 the same cycle; next cycle reg_w = 1, w_reg_addr = 5, w_data = 0xDEADBEEF.
- Contention: both valid for 4 cycles (ALU addr 1, load addr 2) -> grants ALU, load, ALU, load; output addresses 1, 2, 1, 2 on consecutive cycles.
- Clear: pulse clr_start with both valid -> no ready for 33 cycles; reg_w = 1 with addresses 0..31, data 0; clr_done high with address 31; ALU granted the cycle after busy falls.
- Reset mid-CLEAR at cnt = 10 -> all outputs return to reset values immediately; state IDLE; no clr_done pulse.
- R0 protect (macro defined): ALU writes addr 0, data 7 -> alu_ready = 1, reg_w stays 0. Macro undefined -> reg_w = 1, w_reg_addr = 0, w_data = 7.
